// File: rtl/uart_tx.sv
// uart_tx - serial UART transmitter.
//
// Takes a word on a one-cycle tx_start strobe and sends it out LSB-first:
// start bit, DBIT data bits, an optional parity bit, then a stop period.
// Each start/data/parity bit lasts 16 s_ticks and the stop period lasts
// SB_TICK s_ticks. A one-cycle tx_done_tick marks the end of the frame.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop period.
//
// Parameters:
//   DBIT     data bits per frame (5..9)
//   SB_TICK  stop period in s_ticks (16 = 1, 24 = 1.5, 32 = 2 stop bits)
//
// Ports:
//   i_clk         system clock, rising edge
//   i_reset       synchronous active-high reset
//   s_tick        16x oversampling tick from the baud generator
//   tx_start      one-cycle send request, honoured only in IDLE
//   data_in       word to send, sampled on the accepted tx_start cycle
//   tx            serial line, registered, idles high
//   tx_busy       high from the cycle after acceptance through tx_done_tick
//   tx_done_tick  one-cycle pulse on the final stop tick
//
// state  | meaning
// -------+-------------------------------------------------
// IDLE   | line high, waiting for tx_start
// START  | line low for 16 ticks
// DATA   | line = b[0], 16 ticks per bit, shift after each
// PARITY | line = even parity of the word, 16 ticks
// STOP   | line high for SB_TICK ticks, then done pulse
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] data_in,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic            p_q, p_d;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      p_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      p_q     <= p_d;
`endif
    end
  end

  // tx_d is a function of the current state, so the line follows the state
  // register by one clock; every bit is shifted equally and keeps its length.
  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    b_d          = b_q;
    tx_d         = 1'b1;
    tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
    p_d          = p_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        // a tick arriving with tx_start is not counted toward the start bit
        if (tx_start) begin
          state_d = START;
          s_d     = '0;
          b_d     = data_in;
`ifdef UART_TX_PARITY_EN
          p_d     = ^data_in;
`endif
        end
      end
      START: begin
        tx_d = 1'b0;
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            state_d = DATA;
            s_d     = '0;
            n_d     = '0;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        tx_d = b_q[0];
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_d = p_q;
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            state_d = STOP;
            s_d     = '0;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (s_tick) begin
          if (s_q == S_STOP_LAST) begin
            state_d = IDLE;
            s_d     = '0;
            // an abandoned frame must never report completion
            tx_done_tick = ~i_reset;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE);

endmodule
